param_down_counter: RTL
=======================

// Module: param_down_counter
// PURPOSE
//   Parametrised loadable down-counter/timer: next generation of the 8-bit DownCounter pair.
//   Width is generic; the Pre/Post carry-out choice becomes a parameter; one-shot vs auto-reload mode added.
//   Used as the programmable delay/tick source for controller datapaths.
//   Optional dcen prescaler.
// PARAMETERS
//   WIDTH     8  counter, pi and count width in bits (>=2)
//   CO_MODE   0  0 = PRE: co is decoded from the current count; 1 = POST: co is co_pre delayed by one clk
//   PRESCALE  4  dcen cycles per decrement; used only with DOWN_COUNTER_PRESCALER_EN (>=2)
// PORTS
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset
//   dcen    in   1      count enable
//   ld      in   1      load pi; priority over dcen
//   pi      in   WIDTH  load/reload value
//   reload  in   1      sampled on ld: 1 = auto-reload, 0 = one-shot
//   count   out  WIDTH  current count register
//   busy    out  1      state == RUN
//   co      out  1      terminal-count carry-out
// BEHAVIOUR
//   Reset (async, immediate, no clk edge needed):
//     - count = 0, reload_val = 0, mode_q = 0, co = 0, prescale count = 0, state = IDLE.
//   States: IDLE, RUN, DONE.
//     - IDLE: after reset; dcen ignored.
//     - ld: count <= pi, reload_val <= pi, mode_q <= reload; next state RUN if pi != 0, else DONE.
//       ld acts in any state; it wins over dcen and restarts the count.
//   RUN with a decrement tick (dcen, or the prescaler tick), no ld:
//     - count != 0: count <= count - 1.
//     - count == 0, mode_q = 1: count <= reload_val; stay in RUN.
//     - count == 0, mode_q = 0: enter DONE; count holds 0.
//   No tick: count holds; dcen held low at 0 holds 0 and co stays asserted.
//   Underflow: count never wraps to all-ones.
//   DONE: count held at 0; dcen ignored; only ld or rst leaves.
//   co_pre = (state != IDLE) && (count == 0), combinational.
//     - One-shot: co stays high from the first cycle of count == 0 until the next ld.
//     - Auto-reload with dcen=1: 1-cycle co pulse every reload_val+1 cycles.
//   CO_MODE=1: co = flop of co_pre, so exactly 1 clk later; co_pre ^ co differs only on edges.
//   ld with pi = 0: PRE co high the next cycle; POST co high one cycle after that.
//   busy: 1 only in RUN; falls on the same edge that enters DONE.
//   Load latency: count shows pi the cycle after ld.
// CONFIGURATION
//   DOWN_COUNTER_PRESCALER_EN defined:
//     - Internal ceil(log2(PRESCALE))-bit counter advances on dcen while in RUN.
//     - Decrement tick on every PRESCALE-th dcen; prescaler cleared on ld and on rst.
//     - Prescale count freezes when dcen = 0.
//   Not defined: every dcen cycle in RUN is a tick; PRESCALE is ignored and no prescaler logic is built.
// STRUCTURE
//   down_counter_pkg: state enum {IDLE, RUN, DONE}; localparams CO_PRE = 0, CO_POST = 1.
//   Sub-module down_counter_prescaler (clk, rst, clr, en, tick).
//     - Instantiated only under DOWN_COUNTER_PRESCALER_EN.
//   Top: state/count/reload registers, co decode, CO_MODE generate.
// TESTING
//   1. rst; ld pi=10, reload=0, PRE, dcen=1 -> count 10..0 over 10 clks; co rises at count=0 and holds; busy falls.
//   2. Repeat 1 with CO_MODE=1 -> co rises exactly 1 clk after the PRE instance; XOR of the two is a 1-clk pulse.
//   3. ld pi=3, reload=1, dcen=1 -> count 3,2,1,0,3,...; 1-clk co pulse every 4 clks; busy stays 1.
//   4. At count=7 assert ld+dcen with pi=5 -> count=5 next clk (no decrement); co stays 0.
//   5. rst pulse between clk edges at count=4 -> count=0, co=0 at once; dcen=1 afterwards leaves count at 0, state IDLE.
//   6. DOWN_COUNTER_PRESCALER_EN, PRESCALE=4, ld pi=2, dcen=1 -> decrements every 4 clks; co after 8 dcen clks.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared types and constants for param_down_counter and its prescaler.
// The optional prescaler is enabled by defining DOWN_COUNTER_PRESCALER_EN.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CO_PRE  = 0;
  localparam int CO_POST = 1;

endpackage

// File: rtl/down_counter_prescaler.sv
// Divides the count enable: tick fires on every PRESCALE-th enabled cycle.
// Only instantiated when DOWN_COUNTER_PRESCALER_EN is defined.
module down_counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/param_down_counter.sv
// Loadable down-counter/timer with one-shot or auto-reload mode and PRE/POST carry-out.
// Define DOWN_COUNTER_PRESCALER_EN to divide dcen by PRESCALE before each decrement.
module param_down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CO_MODE  = CO_PRE,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dcen,
  input  logic             ld,
  input  logic [WIDTH-1:0] pi,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             co
);

  state_t           state;
  logic [WIDTH-1:0] reload_val;
  logic             mode_q;
  logic             tick;
  logic             co_pre;

`ifdef DOWN_COUNTER_PRESCALER_EN
  down_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (ld),
    .en  (dcen && (state == RUN)),
    .tick(tick)
  );
`else
  assign tick = dcen && (state == RUN);

  // PRESCALE only matters when the prescaler is built.
  if (PRESCALE < 2) begin : g_prescale_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      reload_val <= '0;
      mode_q     <= 1'b0;
      state      <= IDLE;
    end else if (ld) begin
      count      <= pi;
      reload_val <= pi;
      mode_q     <= reload;
      state      <= (pi != '0) ? RUN : DONE;
    end else if (tick) begin
      // tick is only ever asserted in RUN; zero either reloads or terminates.
      if (count != '0) begin
        count <= count - 1'b1;
      end else if (mode_q) begin
        count <= reload_val;
      end else begin
        state <= DONE;
      end
    end
  end

  assign busy   = (state == RUN);
  assign co_pre = (state != IDLE) && (count == '0);

  if (CO_MODE == CO_POST) begin : g_co_post
    logic co_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        co_q <= 1'b0;
      end else begin
        co_q <= co_pre;
      end
    end
    assign co = co_q;
  end else begin : g_co_pre
    assign co = co_pre;
  end

endmodule
